// File: rtl/skeleton_pkg.sv
// Shared types and constants for the skeleton clock/reset controller.
package skeleton_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    localparam logic [1:0] PH_IMEM = 2'd0;
    localparam logic [1:0] PH_REG  = 2'd1;
    localparam logic [1:0] PH_DMEM = 2'd2;
    localparam logic [1:0] PH_PROC = 2'd3;

endpackage

// File: rtl/skeleton_clk_ctrl_if.sv
// Debug-control inputs and phase/reset outputs between the controller and the core.
interface skeleton_clk_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             halt_req;
    logic             step_req;
    logic             core_reset;
    logic             imem_en;
    logic             regfile_en;
    logic             dmem_en;
    logic             processor_en;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    // master: the controller; slave: whoever requests halt/step and consumes phases
    modport master (
        input  halt_req, step_req,
        output core_reset, imem_en, regfile_en, dmem_en, processor_en, halted, cycle_count
    );

    modport slave (
        output halt_req, step_req,
        input  core_reset, imem_en, regfile_en, dmem_en, processor_en, halted, cycle_count
    );
endinterface

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second clock edge.
module reset_sync (
    input  logic clk,
    input  logic i_rst_n,
    output logic o_rst_n
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end

    assign o_rst_n = r_sync;
endmodule

// File: rtl/skeleton_clk_ctrl.sv
// Stretched core reset, four one-hot phase enables per processor cycle, halt/step debug
// control and a processor-cycle counter for the MIPS skeleton.
module skeleton_clk_ctrl
    import skeleton_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                clock,
    input  logic                reset,
    skeleton_clk_ctrl_if.master bus
);
    logic             w_rst_n;
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_phase, w_phase_nxt;
    logic [7:0]       r_hold_cnt, w_hold_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_core_reset, r_imem_en, r_reg_en, r_dmem_en, r_proc_en, r_halted;
    logic             w_active;

    reset_sync u_reset_sync (
        .clk     (clock),
        .i_rst_n (reset),
        .o_rst_n (w_rst_n)
    );

    // Outputs are registered from next-state so they switch cleanly on the edge.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= HOLD;
            r_phase      <= PH_IMEM;
            r_hold_cnt   <= '0;
            r_count      <= '0;
            r_core_reset <= 1'b1;
            r_imem_en    <= 1'b0;
            r_reg_en     <= 1'b0;
            r_dmem_en    <= 1'b0;
            r_proc_en    <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_count      <= w_count_nxt;
            r_core_reset <= (w_state_nxt == HOLD);
            r_imem_en    <= w_active && (w_phase_nxt == PH_IMEM);
            r_reg_en     <= w_active && (w_phase_nxt == PH_REG);
            r_dmem_en    <= w_active && (w_phase_nxt == PH_DMEM);
            r_proc_en    <= w_active && (w_phase_nxt == PH_PROC);
            r_halted     <= (w_state_nxt == HALTED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_hold_nxt  = r_hold_cnt;
        w_count_nxt = r_count;
        case (r_state)
            HOLD: begin
                if (r_hold_cnt == 8'(RESET_HOLD - 1)) begin
                    w_state_nxt = RUN;
                    w_phase_nxt = PH_IMEM;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            RUN, STEP: begin
                w_phase_nxt = r_phase + 2'd1;
                // Halt is only honoured at the end of a full processor cycle.
                if (r_phase == PH_PROC) begin
                    w_count_nxt = r_count + CNT_W'(1);
                    if ((r_state == STEP) || bus.halt_req) begin
                        w_state_nxt = HALTED;
                    end
                end
            end
            HALTED: begin
                w_phase_nxt = PH_IMEM;
                if (!bus.halt_req) begin
                    w_state_nxt = RUN;
                end else if (bus.step_req) begin
                    w_state_nxt = STEP;
                end
            end
            default: w_state_nxt = HOLD;
        endcase
        w_active = (w_state_nxt == RUN) || (w_state_nxt == STEP);
    end

    assign bus.core_reset   = r_core_reset;
    assign bus.imem_en      = r_imem_en;
    assign bus.regfile_en   = r_reg_en;
    assign bus.dmem_en      = r_dmem_en;
    assign bus.processor_en = r_proc_en;
    assign bus.halted       = r_halted;
    assign bus.cycle_count  = r_count;
endmodule

// File: doc/skeleton_clk_ctrl.md
# skeleton_clk_ctrl

Clock/reset controller that sits in front of the MIPS skeleton and drives it in hardware the way the bench drives it in simulation. It turns the single board clock and an asynchronous active-low reset into a stretched, synchronously released core reset and four one-hot phase enables (imem, regfile, dmem, processor) per processor cycle. It also provides halt/single-step debug control and a free-running processor-cycle counter.

## Interface
- RESET_HOLD, 4: cycles core_reset stays asserted after reset is released (legal range 2..255).
- CNT_W, 32: width of cycle_count.
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- halt_req  in  1  level; request to stop at the next processor-cycle boundary.
- step_req  in  1  pulse; while halted, run exactly one processor cycle.
- core_reset  out  1  active-high reset to skeleton; asserts asynchronously, deasserts synchronously.
- imem_en  out  1  phase 0 enable (instruction fetch).
- regfile_en  out  1  phase 1 enable (register read/write).
- dmem_en  out  1  phase 2 enable (data memory access).
- processor_en  out  1  phase 3 enable (PC/pipeline state commit).
- halted  out  1  high while in HALTED.
- cycle_count  out  CNT_W  completed processor cycles since reset.

## Operation
- FSM states: HOLD, RUN, HALTED, STEP.
- HOLD: entered asynchronously on reset low. core_reset=1, all enables 0, hold counter counts clock edges once reset is high; after RESET_HOLD edges with reset high -> RUN (core_reset drops on that edge).
- Reset input passes through a 2-flop synchronizer for release only; assertion clears FSM, counters and outputs immediately.
- RUN: 2-bit phase counter 0->1->2->3->0; exactly one enable high per cycle, selected by phase. cycle_count increments on the edge leaving phase 3 (wraps at 2^CNT_W to 0).
- halt_req sampled at phase 3 only: if high, phase-3 cycle completes, next state HALTED, phase=0. Halts never split a processor cycle.
- HALTED: all enables 0, halted=1, phase held at 0. halt_req low -> RUN from phase 0. step_req high (and halt_req high) -> STEP.
- STEP: runs phases 0..3 once (same enables, cycle_count increments), then returns to HALTED regardless of step_req. step_req during STEP ignored; step_req in RUN/HOLD ignored.
- Simultaneous halt_req low and step_req in HALTED: resume (RUN) wins.
- Reset mid-cycle (any state/phase): immediate HOLD, no partial enable completes.

## Timing
- Reset values: core_reset=1, imem_en=regfile_en=dmem_en=processor_en=0, halted=0, cycle_count=0.
- Reset release to core_reset low: 2 synchronizer edges + RESET_HOLD edges.
- First imem_en: the edge where core_reset falls (phase 0 in the same cycle core_reset is 0).
- Processor cycle = 4 clocks; enables registered, glitch-free, mutually exclusive.
- halt_req at phase 3 -> halted=1 on the next cycle; resume -> imem_en on the cycle after halt_req falls.
- step_req -> imem_en next cycle; halted deasserts during the 4 STEP cycles and reasserts after phase 3.

## Structure
- Shared package skeleton_pkg: FSM state enum (HOLD, RUN, HALTED, STEP), phase constants PH_IMEM=0, PH_REG=1, PH_DMEM=2, PH_PROC=3.
- One sub-module: reset_sync (2-flop async-assert/sync-release synchronizer), reusable by other blocks.

## Test plan
- Reset low 2 cycles, then high with RESET_HOLD=4 -> core_reset high for exactly 6 edges after release, then imem_en, regfile_en, dmem_en, processor_en one-hot in order, repeating every 4 cycles.
- Run 10 processor cycles -> cycle_count=10; with CNT_W=4 run 17 cycles -> cycle_count=1 (wrap).
- Raise halt_req at phase 1 -> phases 2,3 complete, halted=1, all enables 0, cycle_count frozen.
- While halted, pulse step_req 3 times (spaced ≥5 cycles) -> 3 full phase sequences, cycle_count +3, halted returns high after each.
- Drop halt_req and pulse step_req same cycle -> RUN resumes, continuous phases, halted=0.
- Assert reset at phase 2 of RUN -> core_reset=1 and dmem_en=0 same cycle (asynchronous), cycle_count=0, full HOLD sequence repeats.
